test_result_monitor: RTL and testbench
======================================

Name: test_result_monitor

Overview:
- Snoops the core's data-store bus for the riscv-tests "tohost" handshake and reduces it to registered pass/fail/timeout status with cycle and retired-instruction counts.
- Sits directly downstream of the core, beside memory, in every rv32 ISA-test bench.
- Replaces the fixed-tick x3 sample with a precise completion point and the failing test number.

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; word-aligned.
- TIMEOUT, 5000, cycles in RUN before declaring timeout; must be at least 1.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- wr_en  in  1  core data-store valid this cycle.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data.
- wr_strb  in  4  byte enables of the store.
- retire  in  1  one instruction retired this cycle.
- done  out  1  sticky; high once any terminal state is reached.
- done_pulse  out  1  high for exactly one cycle on entry to a terminal state.
- pass  out  1  sticky; test passed.
- fail  out  1  sticky; test failed.
- timeout  out  1  sticky; TIMEOUT expired without a verdict.
- fail_test  out  31  failing test number, equal to tohost value >> 1.
- cycles  out  CNT_W  cycles spent in RUN.
- instret  out  CNT_W  retire pulses counted in RUN.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN; all outputs 0; counters 0.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and sticky until reset.
- A tohost hit is wr_en=1, wr_addr==TOHOST_ADDR, wr_strb==4'hF and wr_data!=0.
  - wr_data==0 is the riscv-tests clear store and is ignored.
  - A partial-strobe store to TOHOST_ADDR is ignored.
  - A store to any other address is ignored.
- RUN, on a hit:
  - wr_data==1 -> PASS.
  - wr_data[0]==1 and wr_data!=1 -> FAIL; fail_test <= wr_data[31:1].
  - wr_data[0]==0 (non-zero even value, device command) is ignored; stay in RUN.
- RUN, no hit and cycles==TIMEOUT-1 -> TIMEOUT.
- A hit on the same cycle as timeout expiry: the hit wins (PASS or FAIL).
- Latency: status is registered. pass/fail/done/done_pulse assert in the cycle after the hit's rising edge, i.e. visible one edge later.
- done = pass|fail|timeout. done_pulse is high only in the first cycle of a terminal state.
- Counters:
  - cycles increments every cycle in RUN, including the hit cycle.
  - instret increments on each retire while in RUN, including the hit cycle.
  - Both freeze on entry to a terminal state.
  - Both saturate at all-ones and never wrap.
- In a terminal state, all bus activity is ignored; outputs and fail_test hold.
- Reset asserted mid-run or in a terminal state returns to the reset values asynchronously. Counting restarts on the first rising edge with rst=1.
- X on wr_* while wr_en=0 must not affect state.
- No combinational path from inputs to outputs.

Test Plan:
- Release reset; retire high every cycle; at cycle 40 store wr_addr=TOHOST_ADDR, wr_strb=F, wr_data=1 -> next cycle pass=1, done=1, done_pulse=1 for one cycle, cycles=41, instret=41; all outputs frozen thereafter.
- Store wr_data=0x0000_0007 to tohost -> fail=1, fail_test=3, pass=0. A subsequent store of 1 -> no change.
- Stores of 0, a value of 1 with wr_strb=4'h3, a value of 1 to TOHOST_ADDR+4, and a value of 2 to tohost -> no state change. The following full store of 1 -> pass.
- TIMEOUT=100 with no hit -> timeout=1 and cycles=100 after edge 100. Separately, a hit of 1 exactly in cycle 99 -> pass=1, timeout=0.
- rst driven low between clock edges mid-run, with cycles=57 -> all outputs 0 immediately, without waiting for a clk edge. After release, counting restarts from 0 and a normal pass is detected.
- CNT_W=4, TIMEOUT=40, retire constant -> cycles and instret stick at 15 and do not wrap; timeout still fires.

Source files
------------

// File: rtl/test_result_monitor_if.sv
// Core data-store snoop bus plus retire strobe, as seen by the riscv-tests
// result monitor.
interface test_result_monitor_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        retire;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_strb,
        output retire
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data,
        input wr_strb,
        input retire
    );
endinterface

// File: rtl/test_result_monitor.sv
// Watches the tohost store handshake and reduces it to sticky pass/fail/timeout
// status with saturating cycle and retired-instruction counts.
module test_result_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int unsigned TIMEOUT     = 5000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    test_result_monitor_if.slave   bus,
    output logic                   done,
    output logic                   done_pulse,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [30:0]            fail_test,
    output logic [CNT_W-1:0]       cycles,
    output logic [CNT_W-1:0]       instret
);

    // The timeout timer is separate from the visible cycle counter so that a
    // narrow, saturated cycle counter cannot stop the timeout from firing.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [30:0]        fail_test_q, fail_test_d;
    logic               done_pulse_q, done_pulse_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;
    logic               hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cycles_d     = cycles_q;
        instret_d    = instret_q;
        timer_d      = timer_q;
        fail_test_d  = fail_test_q;
        done_pulse_d = 1'b0;

        // wr_en gates first so undefined address/data while idle cannot leak in
        hit = bus.wr_en && (bus.wr_addr == TOHOST_ADDR) &&
              (bus.wr_strb == 4'hF) && (bus.wr_data != 32'd0);

        if (state_q == ST_RUN) begin
            cycles_d = sat_inc(cycles_q);
            if (bus.retire) begin
                instret_d = sat_inc(instret_q);
            end
            if (timer_q != TMR_LAST) begin
                timer_d = timer_q + 1'b1;
            end

            // Even non-zero values are device commands; they fall through to
            // the timeout check like any other non-verdict cycle.
            if (hit && (bus.wr_data == 32'd1)) begin
                state_d      = ST_PASS;
                done_pulse_d = 1'b1;
            end else if (hit && bus.wr_data[0]) begin
                state_d      = ST_FAIL;
                fail_test_d  = bus.wr_data[31:1];
                done_pulse_d = 1'b1;
            end else if (timer_q == TMR_LAST) begin
                state_d      = ST_TIMEOUT;
                done_pulse_d = 1'b1;
            end
        end

        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
        done_d    = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            cycles_q     <= '0;
            instret_q    <= '0;
            timer_q      <= '0;
            fail_test_q  <= '0;
            done_pulse_q <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            instret_q    <= instret_d;
            timer_q      <= timer_d;
            fail_test_q  <= fail_test_d;
            done_pulse_q <= done_pulse_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
        end
    end

    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign fail_test  = fail_test_q;
    assign cycles     = cycles_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: three instances (default, short
// timeout, narrow counters) share one snoop bus.
module tb_test_result_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    test_result_monitor_if bus_if ();

    // Default instance
    logic        a_done, a_dp, a_pass, a_fail, a_to;
    logic [30:0] a_ft;
    logic [31:0] a_cyc, a_ins;
    // TIMEOUT=100 instance
    logic        b_done, b_dp, b_pass, b_fail, b_to;
    logic [30:0] b_ft;
    logic [31:0] b_cyc, b_ins;
    // CNT_W=4, TIMEOUT=40 instance
    logic        c_done, c_dp, c_pass, c_fail, c_to;
    logic [30:0] c_ft;
    logic [3:0]  c_cyc, c_ins;

    test_result_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT(5000), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_if.slave),
        .done(a_done), .done_pulse(a_dp), .pass(a_pass), .fail(a_fail),
        .timeout(a_to), .fail_test(a_ft), .cycles(a_cyc), .instret(a_ins)
    );

    test_result_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT(100), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .bus(bus_if.slave),
        .done(b_done), .done_pulse(b_dp), .pass(b_pass), .fail(b_fail),
        .timeout(b_to), .fail_test(b_ft), .cycles(b_cyc), .instret(b_ins)
    );

    test_result_monitor #(.TOHOST_ADDR(TOHOST), .TIMEOUT(40), .CNT_W(4)) u_dut_c (
        .clk(clk), .rst(rst), .bus(bus_if.slave),
        .done(c_done), .done_pulse(c_dp), .pass(c_pass), .fail(c_fail),
        .timeout(c_to), .fail_test(c_ft), .cycles(c_cyc), .instret(c_ins)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus_if.wr_en   = 1'b0;
        bus_if.wr_addr = 32'hDEAD_BEEF;
        bus_if.wr_data = 32'h0000_0001;
        bus_if.wr_strb = 4'hF;
    endtask

    // One store, active for exactly one rising edge
    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = addr;
        bus_if.wr_data = data;
        bus_if.wr_strb = strb;
        step(1);
        bus_idle();
    endtask

    task automatic apply_reset(input logic ret);
        bus_idle();
        bus_if.retire = ret;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    initial begin
        bus_if.retire = 1'b0;
        bus_idle();

        // Reset values while rst is held low
        step(2);
        check_eq("rst_done",    {63'd0, a_done}, 64'd0);
        check_eq("rst_pass",    {63'd0, a_pass}, 64'd0);
        check_eq("rst_cycles",  {32'd0, a_cyc},  64'd0);
        check_eq("rst_ft",      {33'd0, a_ft},   64'd0);

        // Pass at cycle 40 with retire every cycle
        apply_reset(1'b1);
        step(40);
        check_eq("t1_cyc40",    {32'd0, a_cyc}, 64'd40);
        store(TOHOST, 32'd1, 4'hF);
        check_eq("t1_pass",     {63'd0, a_pass}, 64'd1);
        check_eq("t1_done",     {63'd0, a_done}, 64'd1);
        check_eq("t1_dpulse",   {63'd0, a_dp},   64'd1);
        check_eq("t1_cycles",   {32'd0, a_cyc},  64'd41);
        check_eq("t1_instret",  {32'd0, a_ins},  64'd41);
        step(1);
        check_eq("t1_dpulse_off", {63'd0, a_dp}, 64'd0);
        store(TOHOST, 32'd7, 4'hF);
        step(3);
        check_eq("t1_frz_pass", {63'd0, a_pass}, 64'd1);
        check_eq("t1_frz_fail", {63'd0, a_fail}, 64'd0);
        check_eq("t1_frz_cyc",  {32'd0, a_cyc},  64'd41);
        check_eq("t1_frz_ins",  {32'd0, a_ins},  64'd41);

        // Fail with test number 3, then a later pass store is ignored
        apply_reset(1'b0);
        store(TOHOST, 32'h0000_0007, 4'hF);
        check_eq("t2_fail",     {63'd0, a_fail}, 64'd1);
        check_eq("t2_pass",     {63'd0, a_pass}, 64'd0);
        check_eq("t2_ft",       {33'd0, a_ft},   64'd3);
        check_eq("t2_dpulse",   {63'd0, a_dp},   64'd1);
        check_eq("t2_instret",  {32'd0, a_ins},  64'd0);
        store(TOHOST, 32'd1, 4'hF);
        check_eq("t2_hold_fail", {63'd0, a_fail}, 64'd1);
        check_eq("t2_hold_pass", {63'd0, a_pass}, 64'd0);
        check_eq("t2_hold_ft",   {33'd0, a_ft},   64'd3);
        check_eq("t2_hold_cyc",  {32'd0, a_cyc},  64'd1);

        // Ignored stores, then a real pass
        apply_reset(1'b0);
        store(TOHOST,          32'd0, 4'hF);
        store(TOHOST,          32'd1, 4'h3);
        store(TOHOST + 32'd4,  32'd1, 4'hF);
        store(TOHOST,          32'd2, 4'hF);
        check_eq("t3_no_done",  {63'd0, a_done}, 64'd0);
        check_eq("t3_cyc",      {32'd0, a_cyc},  64'd4);
        store(TOHOST, 32'd1, 4'hF);
        check_eq("t3_pass",     {63'd0, a_pass}, 64'd1);
        check_eq("t3_cyc_pass", {32'd0, a_cyc},  64'd5);

        // Timeout after 100 cycles
        apply_reset(1'b0);
        step(99);
        check_eq("t4_to_early", {63'd0, b_to},  64'd0);
        check_eq("t4_cyc99",    {32'd0, b_cyc}, 64'd99);
        step(1);
        check_eq("t4_timeout",  {63'd0, b_to},   64'd1);
        check_eq("t4_done",     {63'd0, b_done}, 64'd1);
        check_eq("t4_dpulse",   {63'd0, b_dp},   64'd1);
        check_eq("t4_cyc100",   {32'd0, b_cyc},  64'd100);
        step(1);
        check_eq("t4_cyc_hold", {32'd0, b_cyc},  64'd100);
        check_eq("t4_dp_off",   {63'd0, b_dp},   64'd0);

        // Hit in the expiry cycle wins
        apply_reset(1'b0);
        step(99);
        store(TOHOST, 32'd1, 4'hF);
        check_eq("t4b_pass",    {63'd0, b_pass}, 64'd1);
        check_eq("t4b_no_to",   {63'd0, b_to},   64'd0);
        check_eq("t4b_cyc",     {32'd0, b_cyc},  64'd100);

        // Asynchronous reset between edges at cycles=57
        apply_reset(1'b1);
        step(57);
        check_eq("t5_cyc57",    {32'd0, a_cyc},  64'd57);
        check_eq("t5_c_to",     {63'd0, c_to},   64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t5_async_cyc",  {32'd0, a_cyc},  64'd0);
        check_eq("t5_async_ins",  {32'd0, a_ins},  64'd0);
        check_eq("t5_async_cto",  {63'd0, c_to},   64'd0);
        check_eq("t5_async_cdone", {63'd0, c_done}, 64'd0);
        step(1);
        rst = 1'b1;
        step(3);
        check_eq("t5_restart",  {32'd0, a_cyc},  64'd3);
        store(TOHOST, 32'd1, 4'hF);
        check_eq("t5_pass",     {63'd0, a_pass}, 64'd1);
        check_eq("t5_pass_cyc", {32'd0, a_cyc},  64'd4);

        // Narrow counters saturate, timeout still fires
        apply_reset(1'b1);
        step(39);
        check_eq("t6_cyc_sat",  {60'd0, c_cyc}, 64'd15);
        check_eq("t6_ins_sat",  {60'd0, c_ins}, 64'd15);
        check_eq("t6_to_early", {63'd0, c_to},  64'd0);
        step(1);
        check_eq("t6_timeout",  {63'd0, c_to},  64'd1);
        check_eq("t6_cyc_hold", {60'd0, c_cyc}, 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
